// File: rtl/fifo_uart_drain_pkg.sv
// Shared types and helpers for the FIFO-to-UART drain path.
// Optional even-parity framing is enabled by defining FIFO_UART_PARITY_EN.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

package fifo_uart_drain_pkg;

  localparam int unsigned DEF_DATA_W = `BIT_DEPTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  function automatic int unsigned nbytes(input int unsigned width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/fifo_uart_drain_uart_tx_byte.sv
// One-byte UART transmitter (start, 8 data bits LSB first, stop).
// FIFO_UART_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_byte
  import fifo_uart_drain_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       done_c,
  output logic       tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;
`ifdef FIFO_UART_PARITY_EN
  logic             parity;
`endif

  assign bit_end = (baud_cnt == CNT_MAX);
  assign done_c  = (state == ST_STOP) && bit_end;

  // start has priority so the next byte can begin on the last stop-bit cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
`ifdef FIFO_UART_PARITY_EN
      parity   <= 1'b0;
`endif
    end else if (start) begin
      state    <= ST_START;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= byte_in;
      tx       <= 1'b0;
`ifdef FIFO_UART_PARITY_EN
      parity   <= ^byte_in;
`endif
    end else begin
      baud_cnt <= (state == ST_IDLE || bit_end) ? '0 : CNT_W'(baud_cnt + 1'b1);
      case (state)
        ST_START: begin
          if (bit_end) begin
            state <= ST_DATA;
            tx    <= shreg[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_PARITY_EN
              state <= ST_PARITY;
              tx    <= parity;
`else
              state <= ST_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= 3'(bit_idx + 3'd1);
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end
        end
`ifdef FIFO_UART_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops FIFO words while enabled and streams them LSB byte first over UART.
// Parity framing (FIFO_UART_PARITY_EN) lives entirely in uart_tx_byte.
module fifo_uart_drain
  import fifo_uart_drain_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drain_en,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              uart_tx,
  output logic              busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned NBYTES       = nbytes(DATA_W);
  localparam int unsigned WORD_W       = NBYTES * 8;
  localparam int unsigned IDX_W        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            state;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  byte_idx;
  logic [IDX_W-1:0]  nxt_idx;
  logic              avail_c;
  logic              more_c;
  logic              start_c;
  logic              done_c;
  logic [7:0]        byte_c;

  assign avail_c = drain_en && !fifo_empty;
  assign more_c  = (byte_idx != LAST_IDX);
  assign nxt_idx = IDX_W'(byte_idx + 1'b1);
  assign start_c = (state == ST_LATCH) || ((state == ST_START) && done_c && more_c);
  // Byte 0 comes straight off the FIFO bus so the start bit lands in the latch cycle
  assign byte_c  = (state == ST_LATCH) ? 8'(fifo_rd_data) : 8'(word >> {nxt_idx, 3'b000});

  // ST_START here means "a byte of the current word is on the line"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      word       <= '0;
      byte_idx   <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (avail_c) begin
            state      <= ST_POP;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_POP: state <= ST_LATCH;
        ST_LATCH: begin
          word     <= WORD_W'(fifo_rd_data);
          byte_idx <= '0;
          state    <= ST_START;
        end
        ST_START: begin
          if (done_c) begin
            if (more_c) begin
              byte_idx <= nxt_idx;
            end else if (avail_c) begin
              state      <= ST_POP;
              fifo_rd_en <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .start  (start_c),
    .byte_in(byte_c),
    .done_c (done_c),
    .tx     (uart_tx)
  );

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: 8-bit and 12-bit instances, FIFO model and UART decoder.
module tb_fifo_uart_drain;

  localparam int unsigned CPB = 10;
`ifdef FIFO_UART_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif
  localparam int FRAME = FB * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  drain_en, fifo_empty, rd_en, tx, busy;
  logic [7:0]  rdd0;
  logic [11:0] rdd1;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] fq[2][$];
  logic [7:0]  eq[2][$];
  int          nb[2];
  bit          inf[2];
  int          fc[2];
  logic [7:0]  sh[2];

  always #5 clk = ~clk;

  fifo_uart_drain #(.CLK_FREQ_HZ(100000000), .BAUD(10000000), .DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .drain_en(drain_en[0]), .fifo_empty(fifo_empty[0]),
    .fifo_rd_en(rd_en[0]), .fifo_rd_data(rdd0), .uart_tx(tx[0]), .busy(busy[0]));

  fifo_uart_drain #(.CLK_FREQ_HZ(100000000), .BAUD(10000000), .DATA_W(12)) u_dut12 (
    .clk(clk), .rst(rst), .drain_en(drain_en[1]), .fifo_empty(fifo_empty[1]),
    .fifo_rd_en(rd_en[1]), .fifo_rd_data(rdd1), .uart_tx(tx[1]), .busy(busy[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [11:0] w);
    fq[c].push_back((c == 0) ? (w & 12'h0FF) : w);
    fifo_empty[c] = 1'b0;
  endtask

  // Cycle i is counted in negedges after the step that changed the inputs
  task automatic trace(input int c, input int n, input int drop_at,
                       output int pops, output int pop1, output int pop2,
                       output int tx_lo, output int b_fall);
    pops = 0; pop1 = -1; pop2 = -1; tx_lo = -1; b_fall = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (rd_en[c]) begin
        pops++;
        if (pop1 < 0) pop1 = i;
        else if (pop2 < 0) pop2 = i;
      end
      if (!tx[c] && tx_lo < 0) tx_lo = i;
      if (!busy[c] && pop1 > 0 && b_fall < 0) b_fall = i;
      if (i == drop_at) drain_en[c] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (fq[0].size() == 0) && (fq[1].size() == 0) && (busy == 2'b00) && !inf[0] && !inf[1];
    end
    chk("drain_complete", 32'(done), 32'd1);
  endtask

  // FIFO model: a strobe seen in one cycle presents the next word before the following edge
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst && rd_en[c]) begin
        logic [11:0] w;
        chk($sformatf("pop_nonempty%0d", c), 32'(fq[c].size() != 0), 32'd1);
        if (fq[c].size() != 0) begin
          w = fq[c].pop_front();
          if (c == 0) rdd0 = w[7:0];
          else rdd1 = w;
          for (int b = 0; b < nb[c]; b++) eq[c].push_back(8'(w >> (8 * b)));
        end
        fifo_empty[c] = (fq[c].size() == 0);
      end
    end
  end

  // UART decoder: samples each bit at its midpoint
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        inf[c] = 1'b0;
        eq[c].delete();
      end else if (!inf[c]) begin
        if (!tx[c]) begin
          inf[c] = 1'b1;
          fc[c] = 0;
        end
      end else begin
        fc[c]++;
        if (fc[c] % CPB == CPB / 2) begin
          int k;
          k = fc[c] / CPB;
          if (k == 0) chk($sformatf("start_bit%0d", c), 32'(tx[c]), 32'd0);
          else if (k <= 8) sh[c][k-1] = tx[c];
`ifdef FIFO_UART_PARITY_EN
          if (k == 9) chk($sformatf("parity%0d", c), 32'(tx[c]), 32'(^sh[c]));
`endif
          if (k == FB - 1) begin
            chk($sformatf("stop_bit%0d", c), 32'(tx[c]), 32'd1);
            chk($sformatf("frame_expected%0d", c), 32'(eq[c].size() != 0), 32'd1);
            if (eq[c].size() != 0) chk($sformatf("rx_byte%0d", c), 32'(sh[c]), 32'(eq[c].pop_front()));
            inf[c] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int pops, pop1, pop2, tx_lo, b_fall;
    nb[0] = (8 + 7) / 8;
    nb[1] = (12 + 7) / 8;
    rst = 1'b1;
    drain_en = 2'b11;
    fifo_empty = 2'b11;
    rdd0 = '0;
    rdd1 = '0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk("rst_tx", 32'(tx[c]), 32'd1);
      chk("rst_rd_en", 32'(rd_en[c]), 32'd0);
      chk("rst_busy", 32'(busy[c]), 32'd0);
    end
    rst = 1'b0;

    // Empty FIFO with draining enabled: line stays idle
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx[0]), 32'd1);
      chk("idle_rd_en", 32'(rd_en[0]), 32'd0);
      chk("idle_busy", 32'(busy[0]), 32'd0);
    end

    push(0, 12'h0A5);
    trace(0, FRAME + 10, -1, pops, pop1, pop2, tx_lo, b_fall);
    chk("a5_pops", 32'(pops), 32'd1);
    chk("a5_pop_cycle", 32'(pop1), 32'd1);
    chk("a5_tx_fall", 32'(tx_lo), 32'd3);
    chk("a5_busy_fall", 32'(b_fall), 32'(FRAME + 3));

    push(0, 12'h001);
    push(0, 12'h0FF);
    trace(0, 2 * FRAME + 15, -1, pops, pop1, pop2, tx_lo, b_fall);
    chk("b2b_pops", 32'(pops), 32'd2);
    chk("b2b_pop2_cycle", 32'(pop2), 32'(FRAME + 3));
    chk("b2b_busy_fall", 32'(b_fall), 32'(2 * FRAME + 5));

    push(1, 12'hABC);
    trace(1, 2 * FRAME + 15, -1, pops, pop1, pop2, tx_lo, b_fall);
    chk("w12_pops", 32'(pops), 32'd1);
    chk("w12_tx_fall", 32'(tx_lo), 32'd3);
    chk("w12_busy_fall", 32'(b_fall), 32'(2 * FRAME + 3));

    // drain_en falls in the middle of data bit 3
    push(0, 12'h03C);
    push(0, 12'h055);
    trace(0, 2 * FRAME + 20, 3 + 4 * CPB + 4, pops, pop1, pop2, tx_lo, b_fall);
    chk("drop_pops", 32'(pops), 32'd1);
    chk("drop_busy_fall", 32'(b_fall), 32'(FRAME + 3));
    chk("drop_left_queued", 32'(fq[0].size()), 32'd1);
    drain_en[0] = 1'b1;
    wait_idle(4 * FRAME);

    // Asynchronous reset in the middle of a frame
    push(0, 12'h007);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx[0]), 32'd1);
    chk("async_rst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    push(0, 12'h007);
    rst = 1'b0;
    trace(0, FRAME + 10, -1, pops, pop1, pop2, tx_lo, b_fall);
    chk("post_rst_pops", 32'(pops), 32'd1);
    chk("post_rst_tx_fall", 32'(tx_lo), 32'd3);
    chk("post_rst_busy_fall", 32'(b_fall), 32'(FRAME + 3));

    // Random words, gaps and drain_en toggling on both instances
    for (int i = 0; i < 40; i++) begin
      int c;
      c = int'($urandom_range(0, 1));
      push(c, 12'($urandom));
      repeat ($urandom_range(0, 120)) @(negedge clk);
      if ($urandom_range(0, 4) == 0) drain_en[c] = ~drain_en[c];
    end
    drain_en = 2'b11;
    wait_idle(30000);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("all_bytes_seen%0d", c), 32'(eq[c].size()), 32'd0);
      chk($sformatf("fifo_drained%0d", c), 32'(fq[c].size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
